// File: rtl/sram_ctrl.sv
// SRAM wordline/data sequencer: write = setup, pulse, recovery; read = pulse, recovery.
// Every output is registered. req_ready is high only in IDLE, so callers hold the request while busy.
module sram_ctrl #(
  parameter int COLS      = 1,
  parameter int ROWS      = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int RECOV_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [COLS-1:0]   rsp_rdata,
  output logic [COLS-1:0]   data_in,
  output logic [ROWS-1:0]   row_wr,
  output logic [ROWS-1:0]   row_rd,
  input  logic [COLS-1:0]   sa_out,
  output logic              busy
);

  localparam int MAXC_SR = (SETUP_CYC > RECOV_CYC) ? SETUP_CYC : RECOV_CYC;
  localparam int MAXC    = (PULSE_CYC > MAXC_SR) ? PULSE_CYC : MAXC_SR;
  localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, RD_PULSE, RECOV} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLS-1:0]   data_in_q, data_in_d;
  logic [COLS-1:0]   rdata_q, rdata_d;
  logic              rsp_valid_d;
  logic              req_ready_q, rsp_valid_q, busy_q;
  logic [ROWS-1:0]   row_wr_q, row_rd_q;
  logic [ROWS-1:0]   row_sel;

  // Out-of-range addresses decode to no row at all.
  always_comb begin
    row_sel = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (32'(addr_d) == i) row_sel[i] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d = req_addr;
          if (req_we) begin
            state_d   = WR_SETUP;
            cnt_d     = CW'(SETUP_CYC - 1);
            data_in_d = req_wdata;
          end else begin
            state_d = RD_PULSE;
            cnt_d   = CW'(PULSE_CYC - 1);
          end
        end
      end
      WR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = WR_PULSE;
          cnt_d   = CW'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = RECOV;
          cnt_d   = CW'(RECOV_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_PULSE: begin
        if (cnt_q == '0) begin
          state_d     = RECOV;
          cnt_d       = CW'(RECOV_CYC - 1);
          rsp_valid_d = 1'b1;
          rdata_d     = (|row_sel) ? sa_out : '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RECOV: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_in_q   <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      row_wr_q    <= '0;
      row_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      row_wr_q    <= (state_d == WR_PULSE) ? row_sel : '0;
      row_rd_q    <= (state_d == RD_PULSE) ? row_sel : '0;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign data_in   = data_in_q;
  assign row_wr    = row_wr_q;
  assign row_rd    = row_rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default timing, a 3-row instance and a slow-timing instance.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // u0: defaults
  logic       v0, we0, rdy0, rv0, busy0;
  logic [1:0] a0;
  logic       wd0, sa0, rd0, din0;
  logic [3:0] rw0, rr0;
  // u1: ROWS=3
  logic       v1, we1, rdy1, rv1, busy1;
  logic [1:0] a1;
  logic       wd1, sa1, rd1, din1;
  logic [2:0] rw1, rr1;
  // u2: SETUP=2 PULSE=3 RECOV=2
  logic       v2, we2, rdy2, rv2, busy2;
  logic [1:0] a2;
  logic       wd2, sa2, rd2, din2;
  logic [3:0] rw2, rr2;

  sram_ctrl u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(a0), .req_wdata(wd0), .rsp_valid(rv0), .rsp_rdata(rd0),
    .data_in(din0), .row_wr(rw0), .row_rd(rr0), .sa_out(sa0), .busy(busy0)
  );

  sram_ctrl #(.ROWS(3), .ADDR_W(2)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(a1), .req_wdata(wd1), .rsp_valid(rv1), .rsp_rdata(rd1),
    .data_in(din1), .row_wr(rw1), .row_rd(rr1), .sa_out(sa1), .busy(busy1)
  );

  sram_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .RECOV_CYC(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
    .req_addr(a2), .req_wdata(wd2), .rsp_valid(rv2), .rsp_rdata(rd2),
    .data_in(din2), .row_wr(rw2), .row_rd(rr2), .sa_out(sa2), .busy(busy2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) step();
    total++; if ({rw0, rr0} !== 8'h00) begin bad++; $display("FAIL rst_rows0: got %h want 00", {rw0, rr0}); end
    total++; if ({din0, rd0, rv0, busy0, rdy0} !== 5'b0) begin bad++; $display("FAIL rst_outs0: got %b want 00000", {din0, rd0, rv0, busy0, rdy0}); end
    total++; if ({rw1, rr1, din1, rd1, rv1, busy1, rdy1} !== 11'b0) begin bad++; $display("FAIL rst_outs1: got %b want 0", {rw1, rr1, din1, rd1, rv1, busy1, rdy1}); end
    total++; if ({rw2, rr2, din2, rd2, rv2, busy2, rdy2} !== 13'b0) begin bad++; $display("FAIL rst_outs2: got %b want 0", {rw2, rr2, din2, rd2, rv2, busy2, rdy2}); end
    rst = 1'b0;
    step();
    total++; if ({rdy0, busy0, rdy1, rdy2} !== 4'b1011) begin bad++; $display("FAIL rst_release: got %b want 1011", {rdy0, busy0, rdy1, rdy2}); end
  endtask

  task automatic test_write;
    logic [3:0] e_rw [5];
    logic       e_rdy [5];
    e_rw  = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    e_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v0 = 1'b1; we0 = 1'b1; a0 = 2'd2; wd0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) v0 = 1'b0;
      total++; if (rw0 !== e_rw[k]) begin bad++; $display("FAIL wr_row_wr[%0d]: got %b want %b", k, rw0, e_rw[k]); end
      total++; if (rr0 !== 4'b0) begin bad++; $display("FAIL wr_row_rd[%0d]: got %b want 0000", k, rr0); end
      total++; if (din0 !== 1'b1) begin bad++; $display("FAIL wr_data_in[%0d]: got %b want 1", k, din0); end
      total++; if (rdy0 !== e_rdy[k]) begin bad++; $display("FAIL wr_ready[%0d]: got %b want %b", k, rdy0, e_rdy[k]); end
      total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL wr_rsp_valid[%0d]: got %b want 0", k, rv0); end
    end
  endtask

  task automatic test_read;
    logic [3:0] e_rr [4];
    logic       e_rv [4];
    logic       e_rdy [4];
    e_rr  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    e_rv  = '{1'b0, 1'b0, 1'b1, 1'b0};
    e_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
    total++; if (rd0 !== 1'b0) begin bad++; $display("FAIL rd_after_write: got %b want 0", rd0); end
    v0 = 1'b1; we0 = 1'b0; a0 = 2'd2; sa0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) begin v0 = 1'b0; sa0 = 1'b1; end
      if (k == 2) sa0 = 1'b0;
      total++; if (rr0 !== e_rr[k]) begin bad++; $display("FAIL rd_row_rd[%0d]: got %b want %b", k, rr0, e_rr[k]); end
      total++; if (rw0 !== 4'b0) begin bad++; $display("FAIL rd_row_wr[%0d]: got %b want 0000", k, rw0); end
      total++; if (rv0 !== e_rv[k]) begin bad++; $display("FAIL rd_rsp_valid[%0d]: got %b want %b", k, rv0, e_rv[k]); end
      total++; if (rdy0 !== e_rdy[k]) begin bad++; $display("FAIL rd_ready[%0d]: got %b want %b", k, rdy0, e_rdy[k]); end
      if (k >= 2) begin
        total++; if (rd0 !== 1'b1) begin bad++; $display("FAIL rd_rdata[%0d]: got %b want 1", k, rd0); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int   acc, e1, e2, rv_n, low;
    logic hs;
    acc = 0; e1 = -1; e2 = -1; rv_n = 0; low = 0;
    v0 = 1'b1; we0 = 1'b1; a0 = 2'd1; wd0 = 1'b0; sa0 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      hs = v0 && rdy0;
      step();
      if (hs) begin
        acc++;
        if (acc == 1) begin e1 = c; we0 = 1'b0; end
        else begin e2 = c; v0 = 1'b0; end
      end
      if (acc == 1 && !rdy0) low++;
      total++; if ($countones({rw0, rr0}) > 1) begin bad++; $display("FAIL b2b_overlap[%0d]: got wr=%b rd=%b want at most one bit", c, rw0, rr0); end
      if (rv0) begin
        rv_n++;
        total++; if (rd0 !== 1'b0) begin bad++; $display("FAIL b2b_rdata: got %b want 0", rd0); end
      end
    end
    total++; if (acc !== 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
    total++; if (low !== 4) begin bad++; $display("FAIL b2b_gap: got %0d busy cycles want 4", low); end
    total++; if (e2 - e1 !== low + 1) begin bad++; $display("FAIL b2b_second_accept: got %0d edges want %0d", e2 - e1, low + 1); end
    total++; if (rv_n !== 1) begin bad++; $display("FAIL b2b_rsp_count: got %0d want 1", rv_n); end
    total++; if (din0 !== 1'b0) begin bad++; $display("FAIL b2b_data_in: got %b want 0", din0); end
  endtask

  task automatic test_out_of_range;
    logic want;
    for (int t = 0; t < 2; t++) begin
      want = (t == 0);
      a1 = (t == 0) ? 2'd0 : 2'd3;
      sa1 = 1'b1; we1 = 1'b0; v1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
        step();
        if (k == 0) v1 = 1'b0;
        if (t == 1) begin
          total++; if ({rw1, rr1} !== 6'b0) begin bad++; $display("FAIL oor_rows[%0d]: got %b want 000000", k, {rw1, rr1}); end
        end else if (k < 2) begin
          total++; if (rr1 !== 3'b001) begin bad++; $display("FAIL oor_inrange_row[%0d]: got %b want 001", k, rr1); end
        end
        if (k == 2) begin
          total++; if (rv1 !== 1'b1) begin bad++; $display("FAIL oor_rsp_valid[%0d]: got %b want 1", t, rv1); end
          total++; if (rd1 !== want) begin bad++; $display("FAIL oor_rdata[%0d]: got %b want %b", t, rd1, want); end
        end
      end
    end
  endtask

  task automatic test_timing;
    int pw, occ, first_p, rvn;
    logic pulse;
    for (int t = 0; t < 2; t++) begin
      pw = 0; occ = -1; first_p = -1; rvn = 0;
      v2 = 1'b1; we2 = (t == 0); a2 = 2'd0; wd2 = 1'b1; sa2 = 1'b1;
      for (int c = 0; c < 12; c++) begin
        step();
        if (c == 0) v2 = 1'b0;
        pulse = (t == 0) ? rw2[0] : rr2[0];
        if (pulse) begin
          pw++;
          if (first_p < 0) first_p = c;
        end
        if (rdy2 && occ < 0) occ = c;
        if (rv2) rvn++;
        total++; if ($countones({rw2, rr2}) > 1) begin bad++; $display("FAIL tim_overlap[%0d]: got %b", c, {rw2, rr2}); end
      end
      total++; if (pw !== 3) begin bad++; $display("FAIL tim_pulse_w[%0d]: got %0d want 3", t, pw); end
      total++; if (occ !== ((t == 0) ? 7 : 5)) begin bad++; $display("FAIL tim_occupancy[%0d]: got %0d want %0d", t, occ, (t == 0) ? 7 : 5); end
      total++; if (first_p !== ((t == 0) ? 2 : 0)) begin bad++; $display("FAIL tim_pulse_start[%0d]: got %0d want %0d", t, first_p, (t == 0) ? 2 : 0); end
      total++; if (rvn !== ((t == 0) ? 0 : 1)) begin bad++; $display("FAIL tim_rsp_count[%0d]: got %0d want %0d", t, rvn, (t == 0) ? 0 : 1); end
    end
    total++; if ({din2, rd2} !== 2'b11) begin bad++; $display("FAIL tim_data: got %b want 11", {din2, rd2}); end
  endtask

  task automatic test_reset_mid;
    int rvn;
    rvn = 0;
    v0 = 1'b1; we0 = 1'b1; a0 = 2'd3; wd0 = 1'b1;
    step();
    v0 = 1'b0;
    total++; if (din0 !== 1'b1) begin bad++; $display("FAIL rm_data_in_load: got %b want 1", din0); end
    step();
    total++; if (rw0 !== 4'b1000) begin bad++; $display("FAIL rm_pulse1: got %b want 1000", rw0); end
    step();
    total++; if (rw0 !== 4'b1000) begin bad++; $display("FAIL rm_pulse2: got %b want 1000", rw0); end
    rst = 1'b1;
    step();
    total++; if ({rw0, rr0} !== 8'h00) begin bad++; $display("FAIL rm_rows: got %h want 00", {rw0, rr0}); end
    total++; if ({din0, busy0, rv0, rdy0} !== 4'b0) begin bad++; $display("FAIL rm_outs: got %b want 0000", {din0, busy0, rv0, rdy0}); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rv0) rvn++;
    end
    total++; if (rvn !== 0) begin bad++; $display("FAIL rm_no_rsp: got %0d want 0", rvn); end
    total++; if ({rdy0, busy0, rw0} !== 6'b100000) begin bad++; $display("FAIL rm_idle: got %b want 100000", {rdy0, busy0, rw0}); end
  endtask

  initial begin
    v0 = 0; we0 = 0; a0 = 0; wd0 = 0; sa0 = 0;
    v1 = 0; we1 = 0; a1 = 0; wd1 = 0; sa1 = 0;
    v2 = 0; we2 = 0; a2 = 0; wd2 = 0; sa2 = 0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_out_of_range();
    test_timing();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
